// File: rtl/bram_model_pkg.sv
// rtl/bram_model_pkg.sv - shared types, default sizes and initial memory image for bram_model_mp
package bram_model_pkg;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_ADDR_W       = 13;
    localparam int DEF_DEPTH        = 16;
    localparam int DEF_N_CH         = 2;
    localparam int DEF_READ_LATENCY = 1;
    localparam int MAX_DATA_W       = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } rd_state_e;

    // Word 0 carries 0xFF in its top byte, the last word 0xFF in its low byte.
    function automatic logic [MAX_DATA_W-1:0] init_word(input int idx, input int depth,
                                                        input int data_w);
        logic [MAX_DATA_W-1:0] w;
        w = '0;
        if (idx == 0) begin
            w[7:0] = 8'hFF;
            w      = w << (data_w - 8);
        end else if (idx == depth - 1) begin
            w[7:0] = 8'hFF;
        end
        return w;
    endfunction

endpackage

// File: rtl/bram_rd_chan.sv
// rtl/bram_rd_chan.sv - one read channel: latency FSM, counter, read-data register and done gating
module bram_rd_chan
    import bram_model_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              trig_i,
    input  logic [DATA_W-1:0] rd_word_i,
    output logic              load_o,
    output logic [DATA_W-1:0] data_o,
    output logic              done_o
);

    localparam logic [7:0] LAT = 8'(READ_LATENCY);

    rd_state_e         state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              done_pre_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            done_pre_q <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_pre_q <= (state_d == ST_DONE);
            if (load_o) begin
                data_q <= rd_word_i;
            end
        end
    end

    // A low trigger at any edge aborts whatever the channel was doing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!trig_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = (READ_LATENCY == 0) ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == LAT) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The edge that enters DONE already captures data, so done and data rise together.
    assign load_o = (state_d == ST_DONE);
    assign data_o = data_q;
    assign done_o = done_pre_q & trig_i;

endmodule

// File: rtl/bram_model_mp.sv
// rtl/bram_model_mp.sv - multi-channel read BRAM model with one write port; BRAM_MODEL_ADDR_CHK_EN enables range checking
module bram_model_mp
    import bram_model_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int N_CH         = DEF_N_CH,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [N_CH*ADDR_W-1:0] i_bram_addr,
    input  logic [N_CH-1:0]        i_bram_trig,
    output logic [N_CH*DATA_W-1:0] o_bram_data,
    output logic [N_CH-1:0]        o_bram_done,
    input  logic                   i_wr_en,
    input  logic [ADDR_W-1:0]      i_wr_addr,
    input  logic [DATA_W-1:0]      i_wr_data,
    output logic [N_CH-1:0]        o_addr_err
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Reset reloads the power-up image rather than clearing to zero.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(init_word(i, DEPTH, DATA_W));
            end
        end else if (i_wr_en) begin
            mem_q[IDX_W'(i_wr_addr)] <= i_wr_data;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rd_word;
        logic              load;
        logic              oob;
        logic              err_q;

        assign addr = i_bram_addr[k*ADDR_W +: ADDR_W];

`ifdef BRAM_MODEL_ADDR_CHK_EN
        assign oob     = ({1'b0, addr} >= (ADDR_W+1)'(DEPTH));
        assign rd_word = oob ? '1 : mem_q[IDX_W'(addr)];
`else
        assign oob     = 1'b0;
        assign rd_word = mem_q[IDX_W'(addr)];
`endif

        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                err_q <= 1'b0;
            end else if (load && oob) begin
                err_q <= 1'b1;
            end
        end

        assign o_addr_err[k] = err_q;

        bram_rd_chan #(
            .DATA_W       (DATA_W),
            .READ_LATENCY (READ_LATENCY)
        ) u_chan (
            .clk_i     (i_clk),
            .rstn_i    (i_rstn),
            .trig_i    (i_bram_trig[k]),
            .rd_word_i (rd_word),
            .load_o    (load),
            .data_o    (o_bram_data[k*DATA_W +: DATA_W]),
            .done_o    (o_bram_done[k])
        );
    end

endmodule

// File: tb/tb_bram_model_mp.sv
// tb/tb_bram_model_mp.sv - self-checking bench for bram_model_mp (latency 1 x4 channels, latency 3 x2 channels)
module tb_bram_model_mp;

`ifdef BRAM_MODEL_ADDR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   tr;
    logic [12:0]  ch_addr [4];
    logic [51:0]  addr_bus;
    logic         wr_en;
    logic [12:0]  wr_addr;
    logic [31:0]  wr_data;
    logic [127:0] data_a;
    logic [3:0]   done_a, err_a;
    logic [63:0]  data_b;
    logic [1:0]   done_b, err_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [31:0] mmem  [16];
    int          mrun  [2][4];
    logic [31:0] mdata [2][4];
    bit          merr  [2][4];

    always #5 clk = ~clk;
    assign addr_bus = {ch_addr[3], ch_addr[2], ch_addr[1], ch_addr[0]};

    bram_model_mp #(.N_CH(4), .READ_LATENCY(1)) dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_bram_addr(addr_bus), .i_bram_trig(tr),
        .o_bram_data(data_a), .o_bram_done(done_a), .i_wr_en(wr_en),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_addr_err(err_a));

    bram_model_mp #(.N_CH(2), .READ_LATENCY(3)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_bram_addr(addr_bus[25:0]), .i_bram_trig(tr[1:0]),
        .o_bram_data(data_b), .o_bram_done(done_b), .i_wr_en(wr_en),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_addr_err(err_b));

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int nch_of(int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic logic [31:0] da(int k);
        return data_a[k*32 +: 32];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mmem[i] = 32'h0;
        mmem[0]  = 32'hFF000000;
        mmem[15] = 32'h000000FF;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                mrun[d][k]  = 0;
                mdata[d][k] = 32'h0;
                merr[d][k]  = 1'b0;
            end
    endtask

    // A channel delivers once it has seen more than LATENCY consecutive high edges.
    task automatic model_edge();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < nch_of(d); k++) begin
                if (tr[k]) begin
                    mrun[d][k] = mrun[d][k] + 1;
                    if (mrun[d][k] > lat_of(d)) begin
                        if (CHK && ch_addr[k] >= 13'd16) begin
                            mdata[d][k] = 32'hFFFFFFFF;
                            merr[d][k]  = 1'b1;
                        end else begin
                            mdata[d][k] = mmem[ch_addr[k][3:0]];
                        end
                    end
                end else begin
                    mrun[d][k] = 0;
                end
            end
        if (wr_en) mmem[wr_addr[3:0]] = wr_data;
    endtask

    always @(posedge clk) begin
        if (rstn) model_edge();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < nch_of(d); k++) begin
                    check($sformatf("dut%0d.ch%0d.data", d, k),
                          (d == 0) ? data_a[k*32 +: 32] : data_b[k*32 +: 32], mdata[d][k]);
                    check($sformatf("dut%0d.ch%0d.done", d, k),
                          {31'b0, (d == 0) ? done_a[k] : done_b[k]},
                          {31'b0, tr[k] && (mrun[d][k] > lat_of(d))});
                    check($sformatf("dut%0d.ch%0d.err", d, k),
                          {31'b0, (d == 0) ? err_a[k] : err_b[k]}, {31'b0, merr[d][k]});
                end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, ".data_a"}, data_a[31:0] | data_a[63:32] | data_a[95:64] | data_a[127:96], 32'h0);
        check({nm, ".data_b"}, data_b[31:0] | data_b[63:32], 32'h0);
        check({nm, ".flags"}, {20'b0, done_a, err_a, done_b, err_b}, 32'h0);
    endtask

    initial begin
        rstn = 1'b1; tr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int k = 0; k < 4; k++) ch_addr[k] = '0;
        #3 rstn = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk); #1 rstn = 1'b1;

        // latency 1: done after 2nd edge, then streaming address change
        tr[0] = 1'b1;
        tick; check("lat1.edge1.done", {31'b0, done_a[0]}, 32'd0);
        tick; check("lat1.edge2.done", {31'b0, done_a[0]}, 32'd1);
              check("lat1.edge2.data", da(0), 32'hFF000000);
        ch_addr[0] = 13'd15;
        tick; check("lat1.stream.data", da(0), 32'h000000FF);
              check("lat1.stream.done", {31'b0, done_a[0]}, 32'd1);
              check("lat3.edge3.done", {31'b0, done_b[0]}, 32'd0);
        tick; tick;
        check("lat3.ch0.data", data_b[31:0], 32'h000000FF);
        check("lat3.ch0.done", {31'b0, done_b[0]}, 32'd1);
        tr[0] = 1'b0;
        tick; check("drop.done", {31'b0, done_a[0]}, 32'd0);
              check("drop.hold", da(0), 32'h000000FF);

        // latency 3 with an aborted request
        ch_addr[1] = 13'd0; tr[1] = 1'b1;
        tick; tick; tr[1] = 1'b0;
        tick; tr[1] = 1'b1;
        repeat (3) begin
            tick; check("lat3.abort.done", {31'b0, done_b[1]}, 32'd0);
        end
        tick; check("lat3.full.done", {31'b0, done_b[1]}, 32'd1);
              check("lat3.full.data", data_b[63:32], 32'hFF000000);

        // read-first collision with the write port
        ch_addr[1] = 13'd5; wr_en = 1'b1; wr_addr = 13'd5; wr_data = 32'hDEADBEEF;
        tick; wr_en = 1'b0;
        check("rf.old_a", da(1), 32'h0);
        check("rf.old_b", data_b[63:32], 32'h0);
        tick; check("rf.new_a", da(1), 32'hDEADBEEF);
        tr[1] = 1'b0;
        tick;

        // four aligned channels on word 0
        for (int k = 0; k < 4; k++) ch_addr[k] = '0;
        tr = 4'hF;
        tick; tick;
        for (int k = 0; k < 4; k++) check($sformatf("align.ch%0d", k), da(k), 32'hFF000000);
        check("align.done", {28'b0, done_a}, 32'hF);

        // reset while dut_a is in DONE and dut_b still waits
        #2 rstn = 1'b0;
        model_reset();
        #1 check_all_zero("midrst");
        ch_addr[0] = 13'd5;
        @(negedge clk); #1 rstn = 1'b1;
        tick; check("postrst.edge1.done", {31'b0, done_a[0]}, 32'd0);
        tick; check("postrst.edge2.done", {31'b0, done_a[0]}, 32'd1);
              check("postrst.restored", da(0), 32'h0);
              check("postrst.word0", da(1), 32'hFF000000);

        // out-of-range address
        ch_addr[0] = 13'd16;
        tick; check("oob.data", da(0), CHK ? 32'hFFFFFFFF : 32'hFF000000);
              check("oob.err", {31'b0, err_a[0]}, {31'b0, CHK});
        ch_addr[0] = 13'd3;
        repeat (3) tick;
        check("oob.sticky", {31'b0, err_a[0]}, {31'b0, CHK});
        tr = '0;
        tick;

        // streaming reads on channels 2/3 against concurrent writes
        tr[3:2] = 2'b11;
        for (int i = 0; i < 12; i++) begin
            ch_addr[2] = 13'(i);
            ch_addr[3] = 13'(15 - i);
            wr_en   = 1'b1;
            wr_addr = 13'(i + 3);
            wr_data = 32'h10000000 + 32'(i) * 32'h01010101;
            tick;
        end
        wr_en = 1'b0; tr = '0;
        tick;

        rstn = 1'b0;
        model_reset();
        #1 check_all_zero("final_rst");
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
